// File: rtl/bcd_pkg.sv
// Shared widths and FSM encoding for the BCD scan-out decoder.
package bcd_pkg;
  localparam int BCD_W    = 4;
  localparam int ONEHOT_W = 10;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_to_onehot10.sv
// BCD digit to one-hot-10; codes above 9 give all-zero and raise invalid.
module bcd_to_onehot10
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0]    bcd,
  output logic [ONEHOT_W-1:0] onehot,
  output logic                invalid
);
  always_comb begin
    invalid = (bcd > BCD_MAX);
    onehot  = invalid ? '0 : (ONEHOT_W'(1) << bcd);
  end
endmodule

// File: rtl/deshifrator_bcd_scan.sv
// Accepts a frame of packed BCD digits and scans them out one-hot, one digit per SCAN_DIV cycles.
module deshifrator_bcd_scan
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_W*N_DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  output logic [ONEHOT_W-1:0]       out_onehot,
  output logic [N_DIGITS-1:0]       out_digit_sel,
  output logic                      err,
  output logic                      err_frame,
  output logic                      frame_done
);
  localparam int K_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int D_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_DIGITS - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(SCAN_DIV - 1);

  state_t                            state;
  logic [K_W-1:0]                    k;
  logic [K_W-1:0]                    k_nxt;
  logic [D_W-1:0]                    div;
  logic [N_DIGITS-1:0][BCD_W-1:0]    shadow;
  logic [BCD_W-1:0]                  nib;
  logic [ONEHOT_W-1:0]               dec_oh;
  logic                              dec_bad;

  assign in_ready = (state == IDLE);
  assign k_nxt    = (k == K_LAST) ? k : k + 1'b1;

  // One decoder serves both the first digit (straight from in_bcd) and later digits (shadow).
  always_comb nib = (state == IDLE) ? in_bcd[BCD_W-1:0] : shadow[k_nxt];

  bcd_to_onehot10 u_dec (
    .bcd     (nib),
    .onehot  (dec_oh),
    .invalid (dec_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      div           <= '0;
      shadow        <= '0;
      out_valid     <= 1'b0;
      out_onehot    <= '0;
      out_digit_sel <= '0;
      err           <= 1'b0;
      err_frame     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          state         <= SCAN;
          shadow        <= in_bcd;
          k             <= '0;
          div           <= '0;
          out_valid     <= 1'b1;
          out_onehot    <= dec_oh;
          out_digit_sel <= N_DIGITS'(1);
          err           <= dec_bad;
          err_frame     <= dec_bad;
        end
        SCAN: begin
          if (div != D_LAST) begin
            div <= div + 1'b1;
          end else if (k != K_LAST) begin
            k             <= k_nxt;
            div           <= '0;
            out_onehot    <= dec_oh;
            out_digit_sel <= N_DIGITS'(1) << k_nxt;
            err           <= dec_bad;
            err_frame     <= err_frame | dec_bad;
          end else begin
            // err_frame deliberately survives into IDLE until the next acceptance.
            state         <= IDLE;
            frame_done    <= 1'b1;
            out_valid     <= 1'b0;
            out_onehot    <= '0;
            out_digit_sel <= '0;
            err           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deshifrator_bcd_scan.sv
// Scoreboard bench: three decoder instances (4x4, 4 digits at SCAN_DIV=1, 1 digit at SCAN_DIV=4).
module tb_deshifrator_bcd_scan;
  typedef struct packed {
    logic       v;
    logic [9:0] oh;
    logic [7:0] sel;
    logic       e;
    logic       ef;
    logic       fd;
  } obs_t;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] dig;
    obs_t       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic [15:0] bcd;

  logic [2:0]  ordy, ov, oe, oef, ofd;
  logic [9:0]  ooh [3];
  logic [7:0]  osel [3];
  logic [3:0]  a_sel, b_sel;
  logic [0:0]  c_sel;

  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [2:0] last_ef = '0;

  localparam int ND [3] = '{4, 4, 1};
  localparam int SD [3] = '{4, 1, 4};

  always #5 clk = ~clk;

  deshifrator_bcd_scan #(.N_DIGITS(4), .SCAN_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ordy[0]), .in_bcd(bcd),
    .out_valid(ov[0]), .out_onehot(ooh[0]), .out_digit_sel(a_sel), .err(oe[0]),
    .err_frame(oef[0]), .frame_done(ofd[0]));

  deshifrator_bcd_scan #(.N_DIGITS(4), .SCAN_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ordy[1]), .in_bcd(bcd),
    .out_valid(ov[1]), .out_onehot(ooh[1]), .out_digit_sel(b_sel), .err(oe[1]),
    .err_frame(oef[1]), .frame_done(ofd[1]));

  deshifrator_bcd_scan #(.N_DIGITS(1), .SCAN_DIV(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ordy[2]), .in_bcd(bcd[3:0]),
    .out_valid(ov[2]), .out_onehot(ooh[2]), .out_digit_sel(c_sel), .err(oe[2]),
    .err_frame(oef[2]), .frame_done(ofd[2]));

  assign osel[0] = 8'(a_sel);
  assign osel[1] = 8'(b_sel);
  assign osel[2] = 8'(c_sel);

  // Reference encoder (one-hot-10 -> BCD) used for the loopback check.
  function automatic logic [3:0] shifr(input logic [9:0] oh);
    for (int d = 0; d < 10; d++) if (oh[d]) return 4'(d);
    return 4'hF;
  endfunction

  task automatic push_frame(input int id, input logic [15:0] val);
    logic [3:0] d;
    logic       ef;
    exp_t       x;
    ef = 1'b0;
    for (int k = 0; k < ND[id]; k++) begin
      d  = val[4*k +: 4];
      ef = ef | (d > 4'd9);
      for (int c = 0; c < SD[id]; c++) begin
        x.id    = 2'(id);
        x.dig   = d;
        x.o.v   = 1'b1;
        x.o.oh  = (d > 4'd9) ? 10'd0 : (10'd1 << d);
        x.o.sel = 8'd1 << k;
        x.o.e   = (d > 4'd9);
        x.o.ef  = ef;
        x.o.fd  = 1'b0;
        sb.push_back(x);
      end
    end
    x.id = 2'(id); x.dig = 4'hF;
    x.o  = '{v: 1'b0, oh: 10'd0, sel: 8'd0, e: 1'b0, ef: ef, fd: 1'b1};
    sb.push_back(x);
  endtask

  task automatic send(input int id, input logic [15:0] val, input logic hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ordy[id] && n < 200);
    if (!ordy[id]) begin
      errs++;
      $display("FAIL ready_timeout inst%0d observed in_ready=0 required 1", id);
    end
    iv[id] = 1'b1;
    bcd    = val;
    push_frame(id, val);
    @(negedge clk);
    iv[id] = hold;
  endtask

  // Every cycle each instance is compared against the queue head or the idle expectation.
  always @(posedge clk) begin
    logic r;
    r = rst_n;
    #1;
    for (int i = 0; i < 3; i++) begin : mon
      obs_t o, x;
      logic idle;
      o    = '{v: ov[i], oh: ooh[i], sel: osel[i], e: oe[i], ef: oef[i], fd: ofd[i]};
      idle = 1'b1;
      if (!r) begin
        x = '0;
        last_ef[i] = 1'b0;
      end else if (sb.size() > 0 && sb[0].id == 2'(i)) begin
        exp_t h;
        h = sb.pop_front();
        x = h.o;
        last_ef[i] = h.o.ef;
        idle = 1'b0;
        if (h.o.v && !h.o.e) begin
          checks++;
          assert (shifr(o.oh) === h.dig) else begin
            errs++;
            $error("FAIL loopback inst%0d observed=%0d required=%0d", i, shifr(o.oh), h.dig);
          end
        end
      end else begin
        x = '{v: 1'b0, oh: 10'd0, sel: 8'd0, e: 1'b0, ef: last_ef[i], fd: 1'b0};
      end
      checks++;
      assert (o === x) else begin
        errs++;
        $error("FAIL outputs inst%0d observed v=%b oh=%b sel=%b e=%b ef=%b fd=%b required v=%b oh=%b sel=%b e=%b ef=%b fd=%b",
               i, o.v, o.oh, o.sel, o.e, o.ef, o.fd, x.v, x.oh, x.sel, x.e, x.ef, x.fd);
      end
      if (idle) begin
        checks++;
        assert (ordy[i] === 1'b1) else begin
          errs++;
          $error("FAIL in_ready inst%0d observed=%b required=1", i, ordy[i]);
        end
      end
    end
    if (!r) sb.delete();
  end

  initial begin
    int n;
    rst_n = 1'b0;
    iv    = '0;
    bcd   = '0;
    repeat (2) @(negedge clk);
    // Handshake attempted while in reset must be ignored.
    iv  = 3'b111;
    bcd = 16'h1234;
    @(negedge clk);
    iv    = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(0, 16'h1234, 1'b0);
    repeat (18) @(negedge clk);
    send(0, 16'h9C05, 1'b0);
    repeat (18) @(negedge clk);

    // Back-to-back with in_valid held; in_bcd disturbed mid-scan.
    send(0, 16'h3210, 1'b1);
    repeat (5) @(negedge clk);
    bcd = 16'hFFFF;
    send(0, 16'h7654, 1'b1);
    repeat (3) @(negedge clk);
    bcd = 16'hAAAA;
    send(0, 16'h0098, 1'b0);
    repeat (18) @(negedge clk);

    // Reset while digit 2 is on the outputs.
    send(0, 16'h5678, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(1, 16'h3210, 1'b1);
    send(1, 16'h7654, 1'b1);
    send(1, 16'hB098, 1'b0);
    repeat (8) @(negedge clk);

    for (int d = 0; d < 10; d++) send(2, 16'(d), 1'b1);
    send(2, 16'h000A, 1'b0);
    repeat (8) @(negedge clk);

    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      errs++;
      $display("FAIL drain observed pending=%0d required 0", sb.size());
    end
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
